serial_byte_rx: RTL and testbench

Inbound serial-to-parallel receiver for the Pi↔CPLD link: the receive-side counterpart to the parallel-load/serial-out transmit shifter. It oversamples the Pi-driven serial clock, frame select and data lines in the CPLD system clock domain and assembles MSB-first bytes. It presents each completed byte with a valid/acknowledge handshake to the TI-facing register file, and flags aborted frames.

---
 rtl/tipi_pkg.sv | 7 +
 rtl/tipi_sync.sv | 17 +
 rtl/serial_byte_rx.sv | 82 ++++++++
 tb/tb_serial_byte_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tipi_pkg.sv
// tipi_pkg: constants shared by the TIPI Pi<->CPLD serial link blocks.
package tipi_pkg;
   localparam logic [0:0] RX_IDLE  = 1'b0;
   localparam logic [0:0] RX_SHIFT = 1'b1;
   localparam int TIPI_DATA_W   = 8;
   localparam int TIPI_SYNC_MIN = 2;
endpackage

// File: rtl/tipi_sync.sv
// tipi_sync: N-stage single-bit synchronizer, async active-low reset to 0.
module tipi_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;
   always_comb sync_d = {sync_q[N-2:0], d};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else sync_q <= sync_d;
   assign q = sync_q[N-1];
endmodule

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: oversampled MSB-first serial-to-parallel receiver with valid/ack handshake.
// Define SERIAL_RX_OVERRUN_EN to add the sticky overrun port and drop bytes that arrive while one is pending.
module serial_byte_rx
   import tipi_pkg::*;
#(
   parameter int DATA_W      = TIPI_DATA_W,
   parameter int SYNC_STAGES = TIPI_SYNC_MIN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs,
   input  logic              sdin,
   input  logic              rd_ack,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err
`ifdef SERIAL_RX_OVERRUN_EN
   ,
   output logic              overrun
`endif
);
   localparam int CNT_W = $clog2(DATA_W);
   logic sclk_s, cs_s, sdin_s;
   logic rise, shift, done, abort, accept;
   logic              sclk_dly_q, sclk_dly_d;
   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              frame_err_q, frame_err_d;
   tipi_sync #(.N(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
   tipi_sync #(.N(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .q(cs_s));
   tipi_sync #(.N(SYNC_STAGES)) u_sync_sdin (.clk(clk), .rst_n(rst_n), .d(sdin), .q(sdin_s));
`ifdef SERIAL_RX_OVERRUN_EN
   logic overrun_q, overrun_d;
   assign accept = done & (~valid_q | rd_ack);
   always_comb overrun_d = (done & valid_q & ~rd_ack) | (overrun_q & ~rd_ack);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) overrun_q <= 1'b0;
      else overrun_q <= overrun_d;
   assign overrun = overrun_q;
`else
   assign accept = done;
`endif
   // A frame dropping out of SHIFT wins over a coincident sclk rise.
   always_comb begin
      rise        = sclk_s & ~sclk_dly_q;
      shift       = (state_q == RX_SHIFT) & cs_s & rise;
      done        = shift & (bit_cnt_q == CNT_W'(DATA_W - 1));
      abort       = (state_q == RX_SHIFT) & ~cs_s & (bit_cnt_q != '0);
      sclk_dly_d  = sclk_s;
      state_d     = cs_s ? RX_SHIFT : RX_IDLE;
      bit_cnt_d   = !cs_s ? '0 : shift ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
      shreg_d     = !cs_s ? '0 : shift ? {shreg_q[DATA_W-2:0], sdin_s} : shreg_q;
      data_d      = accept ? {shreg_q[DATA_W-2:0], sdin_s} : data_q;
      valid_d     = accept | (valid_q & ~rd_ack);
      frame_err_d = abort;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sclk_dly_q  <= 1'b0;
         state_q     <= RX_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_dly_q  <= sclk_dly_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: directed stimulus with a latency-checking byte scoreboard.
// Works with or without SERIAL_RX_OVERRUN_EN defined.
module tb_serial_byte_rx;
   localparam int SS = 2;
   typedef struct {
      logic [7:0] d;
      int         due;
   } exp_t;
   logic       clk = 0, rst_n = 0, sclk = 0, cs = 0, sdin = 0, rd_ack = 0;
   logic [7:0] data;
   logic       valid, frame_err;
`ifdef SERIAL_RX_OVERRUN_EN
   logic       overrun;
`endif
   int         cyc = 0, tests = 0, fails = 0, fe_cnt = 0;
   exp_t       sb[$];
   logic       pv = 0;
   logic [7:0] pd = 0;
   serial_byte_rx #(.DATA_W(8), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .sdin(sdin), .rd_ack(rd_ack),
      .data(data), .valid(valid), .frame_err(frame_err)
`ifdef SERIAL_RX_OVERRUN_EN
      , .overrun(overrun)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Every newly presented byte must match the next expected one, on its due cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (frame_err) fe_cnt++;
      if (rst_n && valid && (!pv || data != pd)) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got byte %h at cycle %0d, none expected", data, cyc);
         end else begin
            e = sb.pop_front();
            if (data !== e.d || cyc != e.due) begin
               fails++;
               $display("FAIL sb_byte: got %h at cycle %0d, want %h at cycle %0d", data, cyc, e.d, e.due);
            end
         end
      end
      pv = valid;
      pd = data;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   task automatic shift_bits(input logic [7:0] b, input int n, input bit push, input bit ack_done);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         sdin = b[7-i];
         sclk = 0;
         tick(3);
         sclk = 1;
         if (i == 7 && push) begin
            e.d = b;
            e.due = cyc + SS + 1;
            sb.push_back(e);
         end
         if (ack_done) begin
            tick(2);
            rd_ack = (i == 7);
            tick(1);
            rd_ack = 0;
         end else tick(3);
         sclk = 0;
      end
   endtask
   task automatic ack();
      rd_ack = 1;
      tick(1);
      rd_ack = 0;
   endtask
   task automatic frame(input logic [7:0] b);
      cs = 1;
      tick(3);
      shift_bits(b, 8, 1, 0);
      cs = 0;
      tick(4);
   endtask
   initial begin
      tick(3);
      check("rst_data", data, 0);
      check("rst_valid", valid, 0);
      check("rst_frame_err", frame_err, 0);
`ifdef SERIAL_RX_OVERRUN_EN
      check("rst_overrun", overrun, 0);
`endif
      rst_n = 1;
      tick(2);
      frame(8'hA5);
      check("a5_data", data, 8'hA5);
      check("a5_valid", valid, 1);
      check("a5_no_frame_err", fe_cnt, 0);
      ack();
      check("a5_ack_clears", valid, 0);
      cs = 1;
      tick(3);
      shift_bits(8'h3C, 8, 1, 0);
      tick(2);
      ack();
      check("3c_ack_clears", valid, 0);
      shift_bits(8'hC3, 8, 1, 0);
      tick(2);
      ack();
      check("c3_ack_clears", valid, 0);
      cs = 0;
      tick(4);
      cs = 1;
      tick(3);
      shift_bits(8'hFF, 5, 0, 0);
      cs = 0;
      tick(4);
      check("abort_frame_err", fe_cnt, 1);
      check("abort_valid", valid, 0);
      check("abort_data", data, 8'hC3);
      frame(8'h12);
      check("12_data", data, 8'h12);
      ack();
      cs = 1;
      tick(3);
      shift_bits(8'h11, 8, 1, 0);
`ifdef SERIAL_RX_OVERRUN_EN
      shift_bits(8'h22, 8, 0, 0);
      check("ovr_data", data, 8'h11);
      check("ovr_set", overrun, 1);
      ack();
      check("ovr_cleared", overrun, 0);
      check("ovr_valid", valid, 0);
`else
      shift_bits(8'h22, 8, 1, 0);
      check("ovw_data", data, 8'h22);
      check("ovw_valid", valid, 1);
      ack();
      check("ovw_ack_clears", valid, 0);
`endif
      cs = 0;
      tick(4);
      cs = 1;
      tick(3);
      shift_bits(8'h11, 8, 1, 0);
      shift_bits(8'h5A, 8, 1, 1);
      check("ackdone_data", data, 8'h5A);
      check("ackdone_valid", valid, 1);
`ifdef SERIAL_RX_OVERRUN_EN
      check("ackdone_overrun", overrun, 0);
`endif
      cs = 0;
      tick(4);
      check("ackdone_no_frame_err", fe_cnt, 1);
      cs = 1;
      tick(3);
      shift_bits(8'hF0, 4, 0, 0);
      rst_n = 0;
      tick(2);
      check("midrst_data", data, 0);
      check("midrst_valid", valid, 0);
      check("midrst_frame_err", frame_err, 0);
`ifdef SERIAL_RX_OVERRUN_EN
      check("midrst_overrun", overrun, 0);
`endif
      rst_n = 1;
      tick(1);
      shift_bits(8'h81, 8, 1, 0);
      cs = 0;
      tick(4);
      check("81_data", data, 8'h81);
      check("81_valid", valid, 1);
      check("81_no_frame_err", fe_cnt, 1);
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
